// File: rtl/wb_master_pkg.sv
// -----------------------------------------------------------------------------
// wb_master_pkg
// Shared definitions for the Wishbone load/store initiator and its alignment
// helper: access-size encodings, FSM state encoding, the byte-lane select
// lookup and the default ack-timeout length.
// -----------------------------------------------------------------------------
package wb_master_pkg;

    // Access size as carried on the core request.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    // Initiator FSM states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_READ     = 2'd1,
        ST_WRITE    = 2'd2,
        ST_MISALIGN = 2'd3
    } state_e;

    // Cycles to wait for an ack before aborting (timeout build only).
    localparam int unsigned LP_DEFAULT_TIMEOUT_CLKS = 256;

    // Byte-lane select for a given size and byte offset within the word.
    // The reserved size selects no lanes; such requests never reach the bus.
    function automatic logic [3:0] sel_lookup(input logic [1:0] size,
                                              input logic [1:0] lane);
        logic [3:0] sel;
        case (size)
            SZ_BYTE: sel = 4'b0001 << lane;
            SZ_HALF: sel = 4'b0011 << lane;
            SZ_WORD: sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/wb_master_lsu_align.sv
// -----------------------------------------------------------------------------
// wb_master_lsu_align
// Purely combinational lane logic for 32-bit Wishbone accesses. Shared with the
// core's fetch/AMO paths.
//
// Ports:
//   i_size        access size (size_e encoding)
//   i_addr_lo     byte offset within the word (addr[1:0])
//   i_unsigned    1 = zero-extend loads, 0 = sign-extend
//   i_wdata       right-justified store data
//   i_bus_rdata   raw 32-bit word returned by the bus
//   o_sel         byte-lane select
//   o_wdata       store data placed on its lanes (replicated into unused lanes)
//   o_rdata       extracted and extended load data
//   o_misaligned  access cannot be performed as a single aligned bus cycle
// -----------------------------------------------------------------------------
module wb_master_lsu_align
    import wb_master_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_bus_rdata,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Equivalent to shifting the bus word right by 8*offset and taking the low
    // byte/half; half offsets are only ever 0 or 2 for aligned accesses.
    assign byte_s = i_bus_rdata[{i_addr_lo, 3'b000} +: 8];
    assign half_s = i_bus_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    // Lane select, store placement, load extension and alignment check.
    always_comb begin
        o_sel        = sel_lookup(i_size, i_addr_lo);
        o_misaligned = 1'b1;
        o_wdata      = i_wdata;
        o_rdata      = i_bus_rdata;
        case (i_size)
            SZ_BYTE: begin
                o_misaligned = 1'b0;
                // Replicating the byte also places it correctly for any offset.
                o_wdata      = {4{i_wdata[7:0]}};
                o_rdata      = {{24{byte_s[7] & ~i_unsigned}}, byte_s};
            end
            SZ_HALF: begin
                o_misaligned = i_addr_lo[0];
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata      = {{16{half_s[15] & ~i_unsigned}}, half_s};
            end
            SZ_WORD: begin
                o_misaligned = |i_addr_lo;
                o_wdata      = i_wdata;
                o_rdata      = i_bus_rdata;
            end
            default: begin
                o_misaligned = 1'b1;
                o_wdata      = i_wdata;
                o_rdata      = i_bus_rdata;
            end
        endcase
    end

endmodule

// File: rtl/wb_master_lsu.sv
// -----------------------------------------------------------------------------
// wb_master_lsu
// Wishbone (pipelined) initiator for core loads and stores. Accepts one request
// at a time, turns it into a single strobe-held cycle on either the read or the
// write master interface, and returns a one-cycle response pulse. Misaligned
// requests are answered without bus activity.
//
// Optional build macro: WB_MASTER_TIMEOUT_EN
//   defined   - a stuck cycle is aborted after P_TIMEOUT_CLKS strobe cycles and
//               answered with o_rsp_error=1.
//   undefined - waits for ack indefinitely; o_rsp_error is tied low.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_req_*/o_req_ready     core request (valid/ready handshake)
//   o_rsp_*                 completion pulse with load data and status
//   *_master_read_*         read interface (stb/ack/addr/data)
//   *_master_write_*        write interface (stb/ack/addr/data/sel)
// -----------------------------------------------------------------------------
module wb_master_lsu
    import wb_master_pkg::*;
#(
    parameter int unsigned P_ADDR_WIDTH   = 32,
    parameter int unsigned P_TIMEOUT_CLKS = LP_DEFAULT_TIMEOUT_CLKS
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_req_stb,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [P_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [1:0]              i_req_size,
    input  logic                    i_req_unsigned,
    input  logic [31:0]             i_req_wdata,
    output logic                    o_rsp_valid,
    output logic [31:0]             o_rsp_rdata,
    output logic                    o_rsp_misaligned,
    output logic                    o_rsp_error,
    output logic                    o_master_read_stb,
    input  logic                    i_master_read_ack,
    output logic [P_ADDR_WIDTH-1:0] o_master_read_addr,
    input  logic [31:0]             i_master_read_data,
    output logic                    o_master_write_stb,
    input  logic                    i_master_write_ack,
    output logic [P_ADDR_WIDTH-1:0] o_master_write_addr,
    output logic [31:0]             o_master_write_data,
    output logic [3:0]              o_master_write_sel
);

    state_e                  state_q, state_d;
    logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]              lane_q, lane_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [3:0]              sel_q, sel_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    rd_stb_q, rd_stb_d;
    logic                    wr_stb_q, wr_stb_d;
    logic                    ready_q, ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_mis_q, rsp_mis_d;

    logic [1:0]              al_size_s;
    logic [1:0]              al_lane_s;
    logic                    al_uns_s;
    logic [3:0]              al_sel_s;
    logic [31:0]             al_wdata_s;
    logic [31:0]             al_rdata_s;
    logic                    al_mis_s;
    logic                    ack_s;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int unsigned LP_TMO_W =
        ($clog2(P_TIMEOUT_CLKS) < 8) ? 8 : $clog2(P_TIMEOUT_CLKS);
    localparam logic [LP_TMO_W-1:0] LP_TMO_LAST = LP_TMO_W'(P_TIMEOUT_CLKS - 1);
    localparam logic [LP_TMO_W-1:0] LP_TMO_ONE  = LP_TMO_W'(1);

    logic [LP_TMO_W-1:0] tmo_q, tmo_d;
    logic                rsp_err_q, rsp_err_d;
`endif

    // One aligner serves both phases: in IDLE it sees the incoming request
    // (sel/data/misalign), afterwards the registered fields (load extraction).
    always_comb begin
        if (state_q == ST_IDLE) begin
            al_size_s = i_req_size;
            al_lane_s = i_req_addr[1:0];
            al_uns_s  = i_req_unsigned;
        end else begin
            al_size_s = size_q;
            al_lane_s = lane_q;
            al_uns_s  = uns_q;
        end
    end

    wb_master_lsu_align u_align (
        .i_size       (al_size_s),
        .i_addr_lo    (al_lane_s),
        .i_unsigned   (al_uns_s),
        .i_wdata      (i_req_wdata),
        .i_bus_rdata  (i_master_read_data),
        .o_sel        (al_sel_s),
        .o_wdata      (al_wdata_s),
        .o_rdata      (al_rdata_s),
        .o_misaligned (al_mis_s)
    );

    // Only the ack of the interface currently strobed can end the cycle.
    always_comb begin
        if (state_q == ST_WRITE) begin
            ack_s = i_master_write_ack;
        end else begin
            ack_s = i_master_read_ack;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lane_d      = lane_q;
        size_d      = size_q;
        uns_d       = uns_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        rd_stb_d    = rd_stb_q;
        wr_stb_d    = wr_stb_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        rsp_mis_d   = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        rsp_err_d   = 1'b0;
        tmo_d       = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_req_stb) begin
                    addr_d  = {i_req_addr[P_ADDR_WIDTH-1:2], 2'b00};
                    lane_d  = i_req_addr[1:0];
                    size_d  = i_req_size;
                    uns_d   = i_req_unsigned;
                    sel_d   = al_sel_s;
                    wdata_d = al_wdata_s;
`ifdef WB_MASTER_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                    if (al_mis_s) begin
                        state_d = ST_MISALIGN;
                    end else if (i_req_we) begin
                        state_d  = ST_WRITE;
                        wr_stb_d = 1'b1;
                    end else begin
                        state_d  = ST_READ;
                        rd_stb_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ, ST_WRITE: begin
                if (ack_s) begin
                    state_d     = ST_IDLE;
                    rd_stb_d    = 1'b0;
                    wr_stb_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (state_q == ST_READ) begin
                        rsp_rdata_d = al_rdata_s;
                    end else begin
                        rsp_rdata_d = 32'h0000_0000;
                    end
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (tmo_q == LP_TMO_LAST) begin
                    state_d     = ST_IDLE;
                    rd_stb_d    = 1'b0;
                    wr_stb_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + LP_TMO_ONE;
                end
`else
                else begin
                    state_d = state_q;
                end
`endif
            end
            ST_MISALIGN: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_mis_d   = 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                rd_stb_d = 1'b0;
                wr_stb_d = 1'b0;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs; reset drops strobes at once and cancels
    // any pending response.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            lane_q      <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            sel_q       <= 4'b0000;
            wdata_q     <= 32'h0000_0000;
            rd_stb_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_mis_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            rd_stb_q    <= rd_stb_d;
            wr_stb_q    <= wr_stb_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_mis_q   <= rsp_mis_d;
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    // Ack-wait counter and error flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tmo_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign o_rsp_error = rsp_err_q;
`else
    assign o_rsp_error = 1'b0;
`endif

    assign o_req_ready         = ready_q;
    assign o_rsp_valid         = rsp_valid_q;
    assign o_rsp_rdata         = rsp_rdata_q;
    assign o_rsp_misaligned    = rsp_mis_q;
    assign o_master_read_stb   = rd_stb_q;
    assign o_master_read_addr  = addr_q;
    assign o_master_write_stb  = wr_stb_q;
    assign o_master_write_addr = addr_q;
    assign o_master_write_data = wdata_q;
    assign o_master_write_sel  = sel_q;

endmodule

// File: doc/wb_master_lsu.md
Name: wb_master_lsu

Overview:
- Wishbone (pipeline) initiator driving the separate read and write master interfaces toward data memory and MMIO.
- Converts a single-outstanding core load/store request (addr, size, sign, data) into one strobe-held bus cycle. Handles byte-lane select, write-data lane placement, read-data extraction/extension and misalignment rejection.
- Sits between the core execute stage and the external memory/peripheral fabric.

Parameters:
- P_ADDR_WIDTH, 32, byte address width of request and bus.
- P_TIMEOUT_CLKS, 256, cycles to wait for ack before abort (only with the optional feature).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous active-high reset.
- i_req_stb  in  1  core request valid.
- o_req_ready  out  1  high in IDLE only; a request is accepted when i_req_stb & o_req_ready.
- i_req_we  in  1  1=store, 0=load.
- i_req_addr  in  P_ADDR_WIDTH  byte address.
- i_req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as misaligned).
- i_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- i_req_wdata  in  32  store data, right-justified.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors.
- o_rsp_misaligned  out  1  qualifies o_rsp_valid.
- o_rsp_error  out  1  qualifies o_rsp_valid (timeout).
- o_master_read_stb  out  1
- i_master_read_ack  in  1
- o_master_read_addr  out  P_ADDR_WIDTH
- i_master_read_data  in  32
- o_master_write_stb  out  1
- i_master_write_ack  in  1
- o_master_write_addr  out  P_ADDR_WIDTH
- o_master_write_data  out  32
- o_master_write_sel  out  4

Behaviour:
- Reset: all outputs 0 except o_req_ready=1; state IDLE. Assertion mid-cycle drops strobes immediately; no response is issued for an aborted request.
- FSM states: IDLE, READ, WRITE, MISALIGN.
- IDLE: on accept, register request fields. Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size 3) -> MISALIGN. Otherwise -> READ or WRITE with the matching stb=1 from the next cycle.
- Bus address: {addr[P_ADDR_WIDTH-1:2],2'b00}, registered and stable while stb is high.
- sel:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Write data: i_req_wdata lane-shifted left by 8*addr[1:0]; the byte is replicated into unused lanes; bits outside sel are don't-care but driven deterministically.
- READ/WRITE: stb is held until an edge where ack=1. That edge clears stb, returns to IDLE and sets o_rsp_valid=1 for exactly the following cycle.
- Load data: captured on the ack edge; the selected lane is shifted right by 8*addr[1:0], then sign- or zero-extended.
- Latency: accept at edge N, stb high from N+1. With a zero-wait responder acking at edge N+2, o_rsp_valid is high in cycle N+2..N+3 and o_req_ready returns the same cycle.
- A new request may be accepted in the cycle o_rsp_valid is high.
- MISALIGN: no bus activity; o_rsp_valid=1 with o_rsp_misaligned=1 one cycle later; -> IDLE.
- Ack with its stb low is ignored. Read ack during WRITE, or write ack during READ, is ignored.
- Only one interface is ever strobed; at most one transaction is outstanding.

Optional Feature:
- WB_MASTER_TIMEOUT_EN defined:
  - An 8+-bit counter clears on stb rise and increments while stb is high without ack.
  - At P_TIMEOUT_CLKS-1 with no ack: drop stb, pulse o_rsp_valid with o_rsp_error=1 and o_rsp_rdata=0, -> IDLE.
  - A late ack after abort is ignored.
- Undefined: waits indefinitely; o_rsp_error tied 0; no counter logic.

Decomposition:
- Shared package (wb_master_pkg):
  - size encodings (SZ_BYTE/HALF/WORD)
  - FSM state encoding
  - sel lookup function
  - default timeout constant
- One natural sub-module: wb_master_lsu_align, combinational. Computes sel, write-lane placement, read extraction/extension and the misaligned flag. It is reused by the core's fetch/AMO paths.

Test Plan:
- Word store 0x1234_5678 to 0x0001_0000, ack 1 cycle after stb -> addr=0x0001_0000, sel=4'hF, data=0x12345678, stb high exactly 1 cycle, rsp_valid 1 cycle, misaligned=0.
- Byte store 0xA5 to 0x0001_0003 -> sel=4'b1000, data[31:24]=0xA5; half store 0xBEEF to 0x0001_0002 -> sel=4'b1100, data[31:16]=0xBEEF.
- Load byte signed at 0x0001_0001 with bus data 0x0000_8000 -> rdata=0xFFFF_FF80; same address unsigned -> 0x0000_0080; load half signed at 0x...2 with bus data 0x8001_0000 -> 0xFFFF_8001.
- Word load at 0x0001_0002 -> no stb on either interface, rsp_valid next cycle with misaligned=1, rdata=0.
- Responder holds ack low 10 cycles -> stb held 11 cycles, address stable; back-to-back request accepted in the rsp_valid cycle; reset asserted while stb high -> stb low immediately, no rsp_valid.
- With WB_MASTER_TIMEOUT_EN and P_TIMEOUT_CLKS=16, no ack -> stb drops after 16 cycles, rsp_valid with error=1; a late ack 2 cycles later produces no response.
